// File: rtl/scroll_pkg.sv
// Shared types and constants for the scrolling message source: character codes,
// 7-segment blank, FSM state encoding and the message ROM.
package scroll_pkg;

    typedef logic [4:0] char_t;

    localparam char_t CH_H     = 5'd16;
    localparam char_t CH_L     = 5'd17;
    localparam char_t CH_O     = 5'd18;
    localparam char_t CH_P     = 5'd19;
    localparam char_t CH_U     = 5'd20;
    localparam char_t CH_R     = 5'd21;
    localparam char_t CH_N     = 5'd22;
    localparam char_t CH_DASH  = 5'd23;
    localparam char_t CH_BLANK = 5'd31;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAD,
        ST_PAUSE,
        ST_DONE
    } state_t;

    localparam int unsigned ROM_DEPTH = 4;
    localparam char_t MSG_ROM [ROM_DEPTH] = '{CH_H, CH_O, CH_L, 5'd10};

    // Out-of-range indices read as blank so MSG_LEN beyond the ROM stays safe.
    function automatic char_t msg_char(input int unsigned i);
        char_t c;
        c = CH_BLANK;
        for (int unsigned k = 0; k < ROM_DEPTH; k++) begin
            if (k == i) c = MSG_ROM[k];
        end
        return c;
    endfunction

endpackage

// File: rtl/scroll_message_source_seg7_char_decoder.sv
// Combinational character-code to active-low gfedcba segment decoder.
module seg7_char_decoder
    import scroll_pkg::*;
(
    input  char_t      char_i,
    output logic [6:0] seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        case (char_i)
            5'd0:     seg_c = 7'b1000000;
            5'd1:     seg_c = 7'b1111001;
            5'd2:     seg_c = 7'b0100100;
            5'd3:     seg_c = 7'b0110000;
            5'd4:     seg_c = 7'b0011001;
            5'd5:     seg_c = 7'b0010010;
            5'd6:     seg_c = 7'b0000010;
            5'd7:     seg_c = 7'b1111000;
            5'd8:     seg_c = 7'b0000000;
            5'd9:     seg_c = 7'b0010000;
            5'd10:    seg_c = 7'b0001000;
            5'd11:    seg_c = 7'b0000011;
            5'd12:    seg_c = 7'b1000110;
            5'd13:    seg_c = 7'b0100001;
            5'd14:    seg_c = 7'b0000110;
            5'd15:    seg_c = 7'b0001110;
            CH_H:     seg_c = 7'b0001001;
            CH_L:     seg_c = 7'b1000111;
            CH_O:     seg_c = 7'b1000000;
            CH_P:     seg_c = 7'b0001100;
            CH_U:     seg_c = 7'b1000001;
            CH_R:     seg_c = 7'b0101111;
            CH_N:     seg_c = 7'b0101011;
            CH_DASH:  seg_c = 7'b0111111;
            default:  seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/scroll_message_source.sv
// Emits the ROM message one character per prescaler tick as 7-segment codes with
// a shift strobe, followed by blank padding; supports loop and pause.
module scroll_message_source
    import scroll_pkg::*;
#(
    parameter  int unsigned MSG_LEN   = 4,
    parameter  int unsigned TICK_DIV  = 25000000,
    parameter  int unsigned BLANK_PAD = 6,
    localparam int unsigned IDX_W     = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
    input  logic             clock,
    input  logic             En,
    input  logic             start,
    input  logic             pause,
    input  logic             loop,
    output logic [6:0]       seg,
    output logic             shift_stb,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] char_idx
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV);
    localparam int unsigned PAD_W = (BLANK_PAD > 0) ? $clog2(BLANK_PAD + 1) : 1;

    state_t           state_q, state_d, saved_q, saved_d, mode;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d, cidx_q, cidx_d;
    logic [PAD_W-1:0] pad_q, pad_d;
    logic [6:0]       seg_q, seg_d, dec_seg;
    logic             stb_q, stb_d, busy_q, busy_d, done_q, done_d;
    logic             tick, eos;

    seg7_char_decoder u_dec (
        .char_i (msg_char(32'(idx_q))),
        .seg_c  (dec_seg)
    );

    always_ff @(posedge clock or negedge En) begin
        if (!En) begin
            state_q <= ST_IDLE;
            saved_q <= ST_RUN;
            cnt_q   <= '0;
            idx_q   <= '0;
            cidx_q  <= '0;
            pad_q   <= '0;
            seg_q   <= SEG_BLANK;
            stb_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            cidx_q  <= cidx_d;
            pad_q   <= pad_d;
            seg_q   <= seg_d;
            stb_q   <= stb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // A released PAUSE behaves as its saved state in the same cycle, so a frozen
    // terminal count fires on the very first unpaused cycle.
    always_comb begin
        state_d = state_q;
        saved_d = saved_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        cidx_d  = cidx_q;
        pad_d   = pad_q;
        seg_d   = seg_q;
        stb_d   = 1'b0;
        eos     = 1'b0;
        mode    = (state_q == ST_PAUSE) ? saved_q : state_q;
        tick    = (cnt_q == CNT_W'(TICK_DIV - 1));

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    pad_d   = '0;
                    saved_d = ST_RUN;
                    state_d = pause ? ST_PAUSE : ST_RUN;
                end
            end
            ST_RUN, ST_PAD, ST_PAUSE: begin
                if (pause) begin
                    state_d = ST_PAUSE;
                    saved_d = mode;
                end else begin
                    state_d = mode;
                    cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);
                    if (tick) begin
                        stb_d = 1'b1;
                        if (mode == ST_RUN) begin
                            seg_d  = dec_seg;
                            cidx_d = idx_q;
                            idx_d  = idx_q + IDX_W'(1);
                            if (idx_q == IDX_W'(MSG_LEN - 1)) begin
                                idx_d = '0;
                                if (BLANK_PAD == 0) eos = 1'b1;
                                else                state_d = ST_PAD;
                            end
                        end else begin
                            seg_d = SEG_BLANK;
                            pad_d = pad_q + PAD_W'(1);
                            if (pad_q == PAD_W'(BLANK_PAD - 1)) eos = 1'b1;
                        end
                    end
                    if (eos) begin
                        pad_d   = '0;
                        idx_d   = '0;
                        state_d = loop ? ST_RUN : ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_RUN) || (state_d == ST_PAD) || (state_d == ST_PAUSE);
        done_d = (state_d == ST_DONE);
    end

    assign seg       = seg_q;
    assign shift_stb = stb_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign char_idx  = cidx_q;

endmodule

// File: tb/tb_scroll_message_source.sv
// Directed bench for scroll_message_source with TICK_DIV=4, MSG_LEN=4, BLANK_PAD=2.
module tb_scroll_message_source;

    localparam logic [6:0] S_H = 7'b0001001;
    localparam logic [6:0] S_O = 7'b1000000;
    localparam logic [6:0] S_L = 7'b1000111;
    localparam logic [6:0] S_A = 7'b0001000;
    localparam logic [6:0] S_B = 7'b1111111;

    logic       clock = 1'b0;
    logic       En    = 1'b1;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       loop  = 1'b0;
    logic [6:0] seg;
    logic       shift_stb, busy, done;
    logic [1:0] char_idx;

    int errors = 0;
    int checks = 0;

    logic [6:0] exp_seg  [8];
    logic [1:0] exp_idx  [8];
    int         exp_edge [8];
    int         nstb;

    scroll_message_source #(
        .MSG_LEN   (4),
        .TICK_DIV  (4),
        .BLANK_PAD (2)
    ) dut (
        .clock     (clock),
        .En        (En),
        .start     (start),
        .pause     (pause),
        .loop      (loop),
        .seg       (seg),
        .shift_stb (shift_stb),
        .busy      (busy),
        .done      (done),
        .char_idx  (char_idx)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic kick();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic set_exp(input int k, input int e, input logic [6:0] s, input logic [1:0] i);
        exp_edge[k] = e;
        exp_seg[k]  = s;
        exp_idx[k]  = i;
    endtask

    task automatic set_oneshot(input int first_gap);
        set_exp(0, 4,              S_H, 2'd0);
        set_exp(1, 4 + first_gap,  S_O, 2'd1);
        set_exp(2, 8 + first_gap,  S_L, 2'd2);
        set_exp(3, 12 + first_gap, S_A, 2'd3);
        set_exp(4, 16 + first_gap, S_B, 2'd3);
        set_exp(5, 20 + first_gap, S_B, 2'd3);
        nstb = 6;
    endtask

    // Steps nedges clocks after the start edge, checking strobe timing, payload and done/busy.
    task automatic play(input string tag, input int nedges, input int pon, input int poff,
                        input int sagain, input int done_e);
        for (int e = 1; e <= nedges; e++) begin
            int  k;
            logic exp_done;
            step();
            k = -1;
            for (int j = 0; j < nstb; j++) if (exp_edge[j] == e) k = j;
            exp_done = (done_e > 0) && (e >= done_e);
            chk($sformatf("%s stb e%0d", tag, e), 32'(shift_stb), 32'(k >= 0));
            if (k >= 0) begin
                chk($sformatf("%s seg e%0d", tag, e), 32'(seg), 32'(exp_seg[k]));
                chk($sformatf("%s idx e%0d", tag, e), 32'(char_idx), 32'(exp_idx[k]));
            end
            chk($sformatf("%s done e%0d", tag, e), 32'(done), 32'(exp_done));
            chk($sformatf("%s busy e%0d", tag, e), 32'(busy), 32'(!exp_done));
            if (e == pon)  pause = 1'b1;
            if (e == poff) pause = 1'b0;
            start = (e == sagain);
        end
        start = 1'b0;
    endtask

    initial begin
        // Reset asserted before any clock edge
        #1 En = 1'b0;
        #2;
        chk("rst seg",  32'(seg),       32'(S_B));
        chk("rst stb",  32'(shift_stb), 32'd0);
        chk("rst busy", 32'(busy),      32'd0);
        chk("rst done", 32'(done),      32'd0);
        chk("rst idx",  32'(char_idx),  32'd0);
        #10 En = 1'b1;
        repeat (10) step();
        chk("idle seg",  32'(seg),       32'(S_B));
        chk("idle stb",  32'(shift_stb), 32'd0);
        chk("idle busy", 32'(busy),      32'd0);
        chk("idle done", 32'(done),      32'd0);

        loop = 1'b0;
        set_oneshot(4);
        kick();
        play("oneshot", 27, -1, -1, -1, 24);
        chk("oneshot seg hold", 32'(seg), 32'(S_B));

        kick();
        play("ignore", 27, -1, -1, 10, 24);

        set_oneshot(14);
        kick();
        play("pause", 37, 7, 17, -1, 34);

        loop = 1'b1;
        set_oneshot(4);
        set_exp(6, 28, S_H, 2'd0);
        nstb = 7;
        kick();
        play("loop", 30, -1, -1, -1, 0);
        repeat (10) step();
        chk("loop stb e40", 32'(shift_stb), 32'd1);
        chk("loop seg e40", 32'(seg),       32'(S_A));

        // Reset between edges while the strobe is high
        #2 En = 1'b0;
        #1;
        chk("arst seg",  32'(seg),       32'(S_B));
        chk("arst stb",  32'(shift_stb), 32'd0);
        chk("arst busy", 32'(busy),      32'd0);
        chk("arst done", 32'(done),      32'd0);
        chk("arst idx",  32'(char_idx),  32'd0);
        loop = 1'b0;
        #3 En = 1'b1;
        step();
        set_oneshot(4);
        nstb = 1;
        kick();
        play("replay", 5, -1, -1, -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scroll_message_source.md
Name: scroll_message_source

Overview:
- Producer end of the scrolling-display chain. Emits a stored message one character at a time as active-low 7-segment codes, plus a one-cycle shift strobe, to the six-digit scrolling shift register.
- Internal prescaler sets the scroll rate.
- Trailing blanks are appended so the text scrolls fully off the display.
- Supports one-shot or looping playback, with pause.

Parameters:
- MSG_LEN, 4, number of characters taken from the package message ROM (>=1).
- TICK_DIV, 25000000, clock cycles per scroll step (>=2); 1 Hz at 25 MHz.
- BLANK_PAD, 6, blank characters emitted after the last message character (>=0).

Ports:
- clock  in  1  system clock, all state on posedge.
- En  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin playback from character 0.
- pause  in  1  level; freezes playback while high.
- loop  in  1  level; sampled at end of padding: 1 = restart message, 0 = finish.
- seg  out  7  active-low segment code, bit order gfedcba; 7'b1111111 = blank.
- shift_stb  out  1  one-cycle pulse; seg valid and stable while high; drives the shift register shift.
- busy  out  1  high in RUN/PAD/PAUSE.
- done  out  1  high in DONE, until next start.
- char_idx  out  clog2(MSG_LEN)  index of the last emitted message character.

Behaviour:
- Reset (En=0, async, immediate): state IDLE, seg=7'b1111111, shift_stb=0, busy=0, done=0, char_idx=0, prescaler=0, pad counter=0.
- States: IDLE, RUN, PAD, PAUSE, DONE.
- IDLE/DONE + start -> RUN. Clears prescaler, index and done.
  - If pause is also high, enter PAUSE directly.
  - start in RUN/PAD/PAUSE is ignored.
- Prescaler counts only in RUN/PAD. Tick when count==TICK_DIV-1; count then wraps to 0.
  - First tick occurs TICK_DIV cycles after start is accepted.
- RUN tick at cycle T, registered at the end of T:
  - seg <= decode(MSG_ROM[idx]), shift_stb <= 1 (high only during T+1), char_idx <= idx.
  - idx <= idx+1.
  - If idx==MSG_LEN-1: go to PAD, or, if BLANK_PAD=0, apply the end-of-sequence rule immediately.
- PAD tick: seg <= 7'b1111111, shift_stb <= 1, pad count += 1. After BLANK_PAD blanks, apply the end-of-sequence rule.
- End-of-sequence rule:
  - loop=1: go to RUN with idx=0, pad=0, prescaler continuing. Spacing stays exactly TICK_DIV.
  - loop=0: go to DONE, done=1, busy=0.
- seg holds its last value between strobes. In DONE it holds the last emitted code (a blank when BLANK_PAD>0).
- PAUSE:
  - pause=1 in RUN/PAD moves to PAUSE; prescaler and counters are frozen; no strobes.
  - pause=0 returns to the saved state (RUN or PAD) and resumes the count from its frozen value.
  - pause and tick in the same cycle: pause wins, no strobe. The count stays at TICK_DIV-1, so a strobe fires on the first unpaused cycle.
- Decoder: 5-bit character codes. Unassigned codes decode to blank.
- Reset mid-strobe: shift_stb drops asynchronously; no partial character is emitted.

Decomposition:
- Package scroll_pkg holds:
  - char_t (5-bit) and the character code constants: 0-15 = hex digits 0-F; 16 H, 17 L, 18 O, 19 P, 20 U, 21 r, 22 n, 23 dash; 31 BLANK.
  - SEG_BLANK = 7'b1111111.
  - State encoding.
  - MSG_ROM constant array, default H,O,L,A.
- Sub-module seg7_char_decoder: combinational, char_t to active-low 7-bit.
- Top module: FSM, prescaler, index and pad counters.

Test Plan:
All tests use TICK_DIV=4, MSG_LEN=4, BLANK_PAD=2, ROM H,O,L,A.
- Reset then idle: hold 10 cycles with no start -> seg=7'b1111111, shift_stb=0, busy=0, done=0.
- One-shot (loop=0), start at cycle 0:
  - Strobes at cycles 4, 8, 12, 16, 20, 24.
  - seg sequence: 0001001 (H), 1000000 (O), 1000111 (L), 0001000 (A), 1111111, 1111111.
  - done=1 from cycle 24 onward.
- Loop mode (loop=1): the 7th strobe, at cycle 28, carries H again. Strobe spacing stays exactly 4 cycles across the wrap.
- Pause mid-run: pause high for 10 cycles starting on a tick cycle -> that strobe is suppressed and fires on the first cycle after release. No other strobes are lost or duplicated; the character order is unchanged.
- Async reset: En pulled low between clock edges during PAD -> all outputs return to reset values immediately. A new start replays from H.
- Start ignored: start pulsed while busy -> no restart, and the strobe sequence is identical to the one-shot case.
